// File: rtl/javk_pkg.sv
// javk_pkg: shared widths, fetch state encoding and prefetch queue entry type.
package javk_pkg;
    localparam int JAVK_ADDR_W = 16;
    localparam int JAVK_DATA_W = 8;
    typedef enum logic {IDLE, FETCH} fetch_state_t;
    typedef struct packed {
        logic [JAVK_ADDR_W-1:0] pc;
        logic [JAVK_DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/javk_fetch_fifo.sv
// javk_fetch_fifo: single-clock prefetch queue of {pc, data} entries.
// Flush wins over push/pop; push and pop together are allowed even when full.
module javk_fetch_fifo import javk_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        din,
    output entry_t        dout,
    output logic [CW-1:0] count
);
    entry_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
    assign dout = mem[rd];
endmodule

// File: rtl/javk_fetch.sv
// javk_fetch: byte-wide instruction prefetcher feeding a small queue.
// Define JAVK_FETCH_WAIT_EN to honour bus_ready; otherwise every FETCH cycle completes.
module javk_fetch import javk_pkg::*; #(
    parameter int DEPTH = 4,
    parameter logic [JAVK_ADDR_W-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   redirect_valid,
    input  logic [JAVK_ADDR_W-1:0] redirect_addr,
    output logic [JAVK_ADDR_W-1:0] addrbus,
    output logic                   bus_req,
    output logic                   rw,
    input  logic [JAVK_DATA_W-1:0] databus,
    input  logic                   bus_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [JAVK_DATA_W-1:0] out_data,
    output logic [JAVK_ADDR_W-1:0] out_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t state, state_nxt;
    logic [JAVK_ADDR_W-1:0] pc;
    logic [CW-1:0] count, count_nxt;
    logic done, pop;
    entry_t head;
`ifdef JAVK_FETCH_WAIT_EN
    assign done = (state == FETCH) && bus_ready;
`else
    logic unused_bus_ready;
    assign unused_bus_ready = bus_ready;
    assign done = state == FETCH;
`endif
    assign out_valid = count != '0;
    assign pop = out_valid && out_ready;
    assign count_nxt = count + CW'(done) - CW'(pop);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc <= RESET_VECTOR;
        end else begin
            state <= state_nxt;
            pc <= redirect_valid ? redirect_addr : pc + JAVK_ADDR_W'(done);
        end
    end
    // A pending wait-state transfer is never abandoned except by redirect.
    always_comb begin
        state_nxt = redirect_valid ? IDLE :
                    (state == FETCH && !done) ? FETCH :
                    (fetch_en && count_nxt < CW'(DEPTH)) ? FETCH : IDLE;
    end
    always_comb begin
        bus_req = state == FETCH;
        addrbus = pc;
        rw = 1'b1;
    end
    javk_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (done),
        .pop   (pop),
        .din   ({pc, databus}),
        .dout  (head),
        .count (count)
    );
    assign out_data = head.data;
    assign out_pc = head.pc;
endmodule

// File: tb/tb_javk_fetch.sv
// tb_javk_fetch: directed scenarios plus random traffic against a queue-based model.
module tb_javk_fetch;
    localparam int DEPTH = 4;
`ifdef JAVK_FETCH_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, fetch_en, redirect_valid, bus_req, rw, bus_ready, out_valid, out_ready;
    logic [15:0] redirect_addr, addrbus, out_pc;
    logic [7:0] databus, out_data;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction
    assign databus = mem_byte(addrbus);

    javk_fetch #(.DEPTH(DEPTH), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .addrbus(addrbus), .bus_req(bus_req), .rw(rw),
        .databus(databus), .bus_ready(bus_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc)
    );

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
        end
    endtask

    // Model: a byte queue, the fetch pointer and whether a bus request is outstanding.
    logic [23:0] q[$];
    logic [15:0] m_pc = 16'h0000;
    bit m_busy = 1'b0;
    bit m_done;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_pc = 16'h0000;
            m_busy = 1'b0;
        end else begin
            m_done = m_busy && (!WAIT || bus_ready);
            if (redirect_valid) begin
                q.delete();
                m_pc = redirect_addr;
                m_busy = 1'b0;
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (m_done) begin
                    q.push_back({m_pc, mem_byte(m_pc)});
                    m_pc = m_pc + 16'd1;
                end
                m_busy = (m_busy && !m_done) || (fetch_en && q.size() < DEPTH);
            end
        end
    end

    always @(negedge clk) begin
        chk("m_bus_req", 32'(bus_req), 32'(m_busy));
        if (m_busy) chk("m_addrbus", 32'(addrbus), 32'(m_pc));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("m_out_pc", 32'(out_pc), 32'(q[0][23:8]));
            chk("m_out_data", 32'(out_data), 32'(q[0][7:0]));
        end
        chk("m_rw", 32'(rw), 32'd1);
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1; bus_ready = 1'b1;
        redirect_valid = 1'b0; redirect_addr = 16'h0000;
        #2;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_addrbus", 32'(addrbus), 32'h0000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        // streaming from reset, 1 byte per cycle
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("s1_pre_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        chk("s1_req_up", 32'(bus_req), 32'd1);
        chk("s1_addr0", 32'(addrbus), 32'h0000);
        chk("s1_empty", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("s1_v0", 32'(out_valid), 32'd1);
        chk("s1_pc0", 32'(out_pc), 32'h0000);
        chk("s1_d0", 32'(out_data), 32'h00);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("s1_pc", 32'(out_pc), 32'(k));
            chk("s1_data", 32'(out_data), 32'(k));
        end
        // queue fills to DEPTH with no consumer
        out_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        chk("s2_full_req", 32'(bus_req), 32'd0);
        chk("s2_full_pc", 32'(out_pc), 32'h0000);
        @(negedge clk);
        chk("s2_hold_req", 32'(bus_req), 32'd0);
        chk("s2_hold_addr", 32'(addrbus), 32'h0004);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("s2_pop_req", 32'(bus_req), 32'd1);
        chk("s2_pop_pc", 32'(out_pc), 32'h0001);
        @(negedge clk);
        chk("s2_refill_req", 32'(bus_req), 32'd0);
        chk("s2_refill_pc", 32'(out_pc), 32'h0001);
`ifdef JAVK_FETCH_WAIT_EN
        // three wait states on address 5
        out_ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        chk("s3_addr", 32'(addrbus), 32'h0005);
        bus_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("s3_hold", 32'(addrbus), 32'h0005);
            chk("s3_hold_req", 32'(bus_req), 32'd1);
        end
        chk("s3_none", 32'(out_valid), 32'd0);
        bus_ready = 1'b1;
        @(negedge clk);
        chk("s3_pc", 32'(out_pc), 32'h0005);
        chk("s3_data", 32'(out_data), 32'h05);
        chk("s3_next", 32'(addrbus), 32'h0006);
`endif
        // redirect with 3 queued and a transfer completing
        out_ready = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        chk("s4_pre_v", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_addr = 16'h1234;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("s4_flush", 32'(out_valid), 32'd0);
        chk("s4_idle", 32'(bus_req), 32'd0);
        chk("s4_addr", 32'(addrbus), 32'h1234);
        @(negedge clk);
        chk("s4_req", 32'(bus_req), 32'd1);
        chk("s4_addr2", 32'(addrbus), 32'h1234);
        @(negedge clk);
        chk("s4_pc", 32'(out_pc), 32'h1234);
        chk("s4_data", 32'(out_data), 32'h26);
        // wrap past FFFF
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 16'hFFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] e;
            e = 16'hFFFE + 16'(k);
            @(negedge clk);
            chk("s5_wrap_pc", 32'(out_pc), 32'(e));
        end
        // back-to-back redirects: last one wins
        redirect_valid = 1'b1;
        redirect_addr = 16'h4000;
        @(negedge clk);
        redirect_addr = 16'h5000;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("s7_addr", 32'(addrbus), 32'h5000);
        repeat (2) @(negedge clk);
        chk("s7_pc", 32'(out_pc), 32'h5000);
        // reset during a stalled transfer
        bus_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("s6_req", 32'(bus_req), 32'd0);
        chk("s6_addr", 32'(addrbus), 32'h0000);
        chk("s6_valid", 32'(out_valid), 32'd0);
        bus_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_nobyte", 32'(out_valid), 32'd0);
        // random traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            fetch_en = ($urandom % 4) != 0;
            out_ready = ($urandom % 2) != 0;
            bus_ready = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_addr = ($urandom % 2) != 0 ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
            if ($urandom % 500 == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
